pc_trace_buffer: RTL

PC_TRACE_BUFFER -- requirements
Module: pc_trace_buffer

---
 rtl/pc_trace_buffer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pc_trace_buffer.sv
// PC trace buffer: captures fetch-stage PC/instruction pairs with a timestamp whenever the
// PC changes (or on the first enabled cycle) and queues them in a small FIFO for a consumer.
module pc_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              if_pc,
    input  logic [31:0]              if_instr,
    input  logic                     trace_en,
    input  logic                     clear,
    output logic                     tr_valid,
    input  logic                     tr_ready,
    output logic [31:0]              tr_pc,
    output logic [31:0]              tr_instr,
    output logic [TS_W-1:0]          tr_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [TS_W-1:0] ts_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic [7:0]      drop_cnt_r;
    logic [31:0]     last_pc_r;
    logic            first_flag_r;
    logic            tr_valid_r;
    logic [31:0]     head_pc_r;
    logic [31:0]     head_instr_r;
    logic [TS_W-1:0] head_ts_r;

    logic [31:0]     mem_pc_r    [DEPTH];
    logic [31:0]     mem_instr_r [DEPTH];
    logic [TS_W-1:0] mem_ts_r    [DEPTH];

    logic            capture_s;
    logic            pop_s;
    logic            full_s;
    logic            push_s;
    logic            drop_s;
    logic [LW-1:0]   level_nxt_s;
    logic [AW-1:0]   rd_ptr_nxt_s;
    logic [31:0]     head_pc_nxt_s;
    logic [31:0]     head_instr_nxt_s;
    logic [TS_W-1:0] head_ts_nxt_s;

    // Capture, push/pop and drop decisions for the current cycle.
    always_comb begin
        capture_s = trace_en && (first_flag_r || (if_pc != last_pc_r));
        pop_s     = tr_valid_r && tr_ready;
        full_s    = (level_r == FULL_LVL);
        push_s    = capture_s && (!full_s || pop_s);
        drop_s    = capture_s && full_s && !pop_s;
    end

    // Next occupancy, read pointer and head entry; clear empties everything.
    always_comb begin
        level_nxt_s  = level_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (clear) begin
            level_nxt_s  = {LW{1'b0}};
            rd_ptr_nxt_s = {AW{1'b0}};
        end else begin
            unique case ({push_s, pop_s})
                2'b10:   level_nxt_s = level_r + LW'(1);
                2'b01:   level_nxt_s = level_r - LW'(1);
                default: level_nxt_s = level_r;
            endcase
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
        end
        // The slot being written this cycle becomes the head when the FIFO drains onto it.
        if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_pc_nxt_s    = if_pc;
            head_instr_nxt_s = if_instr;
            head_ts_nxt_s    = ts_r;
        end else begin
            head_pc_nxt_s    = mem_pc_r[rd_ptr_nxt_s];
            head_instr_nxt_s = mem_instr_r[rd_ptr_nxt_s];
            head_ts_nxt_s    = mem_ts_r[rd_ptr_nxt_s];
        end
    end

    // Free-running timestamp; only reset touches it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    // FIFO control, compare state, drop counter and registered head outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            level_r      <= {LW{1'b0}};
            drop_cnt_r   <= 8'd0;
            last_pc_r    <= 32'd0;
            first_flag_r <= 1'b1;
            tr_valid_r   <= 1'b0;
            head_pc_r    <= 32'd0;
            head_instr_r <= 32'd0;
            head_ts_r    <= {TS_W{1'b0}};
        end else begin
            level_r      <= level_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            tr_valid_r   <= (level_nxt_s != {LW{1'b0}});
            head_pc_r    <= head_pc_nxt_s;
            head_instr_r <= head_instr_nxt_s;
            head_ts_r    <= head_ts_nxt_s;
            if (clear) begin
                wr_ptr_r     <= {AW{1'b0}};
                drop_cnt_r   <= 8'd0;
                first_flag_r <= 1'b1;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (drop_s && (drop_cnt_r != 8'hFF)) begin
                    drop_cnt_r <= drop_cnt_r + 8'd1;
                end else begin
                    drop_cnt_r <= drop_cnt_r;
                end
                if (!trace_en) begin
                    first_flag_r <= 1'b1;
                end else if (capture_s) begin
                    first_flag_r <= 1'b0;
                    last_pc_r    <= if_pc;
                end else begin
                    first_flag_r <= first_flag_r;
                end
            end
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s && !clear) begin
            mem_pc_r[wr_ptr_r]    <= if_pc;
            mem_instr_r[wr_ptr_r] <= if_instr;
            mem_ts_r[wr_ptr_r]    <= ts_r;
        end
    end

    assign tr_valid = tr_valid_r;
    assign tr_pc    = head_pc_r;
    assign tr_instr = head_instr_r;
    assign tr_ts    = head_ts_r;
    assign level    = level_r;
    assign drop_cnt = drop_cnt_r;

endmodule
